// File: rtl/wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_stage
// Brief    : Registered MIPS W-stage result formatter with a 2-entry
//            (main + skid) output buffer and valid/ready handshakes.
//            The optional misalignment check is enabled by defining
//            WB_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 16,
    parameter int PC_INC  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_sel,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_mem,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [DATA_W-1:0]  in_hi,
    input  logic [DATA_W-1:0]  in_lo,
    input  logic [DATA_W-1:0]  in_cp0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               grf_we,
    output logic [RADDR_W-1:0] grf_addr,
    output logic [DATA_W-1:0]  grf_wdata,
    output logic               exc_misalign
);

    localparam logic [3:0] SEL_ALU = 4'd0;
    localparam logic [3:0] SEL_MEM = 4'd1;
    localparam logic [3:0] SEL_PC  = 4'd2;
    localparam logic [3:0] SEL_LUI = 4'd3;
    localparam logic [3:0] SEL_HI  = 4'd4;
    localparam logic [3:0] SEL_LO  = 4'd5;
    localparam logic [3:0] SEL_LB  = 4'd6;
    localparam logic [3:0] SEL_LH  = 4'd7;
    localparam logic [3:0] SEL_LBU = 4'd8;
    localparam logic [3:0] SEL_CP0 = 4'd9;
    localparam logic [3:0] SEL_LHU = 4'd10;

    typedef struct packed {
        logic               v;
        logic               we;
        logic               mis;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  data;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t w_new;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_data;
    logic              w_sel_ok;
    logic              w_mis;
    logic              w_acc;
    logic              w_pop;

    // Byte lane and halfword selection for sub-word loads
    always_comb begin
        w_byte = in_mem[{in_alu[1:0], 3'b000} +: 8];
        w_half = in_alu[1] ? in_mem[31:16] : in_mem[15:0];
    end

    always_comb begin
        w_data   = '0;
        w_sel_ok = 1'b1;
        case (in_sel)
            SEL_ALU: w_data = in_alu;
            SEL_MEM: w_data = in_mem;
            SEL_PC:  w_data = in_pc + DATA_W'(PC_INC);
            SEL_LUI: w_data = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            SEL_HI:  w_data = in_hi;
            SEL_LO:  w_data = in_lo;
            SEL_LB:  w_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            SEL_LH:  w_data = {{(DATA_W-16){w_half[15]}}, w_half};
            SEL_LBU: w_data = {{(DATA_W-8){1'b0}}, w_byte};
            SEL_CP0: w_data = in_cp0;
            SEL_LHU: w_data = {{(DATA_W-16){1'b0}}, w_half};
            default: begin
                w_data   = '0;
                w_sel_ok = 1'b0;
            end
        endcase
    end

`ifdef WB_ALIGN_CHECK_EN
    always_comb begin
        w_mis = (((in_sel == SEL_LH) || (in_sel == SEL_LHU)) && in_alu[0])
              || ((in_sel == SEL_MEM) && (in_alu[1:0] != 2'b00));
    end
`else
    always_comb begin
        w_mis = 1'b0;
    end
`endif

    always_comb begin
        w_new.v    = 1'b1;
        w_new.we   = w_sel_ok & ~w_mis;
        w_new.mis  = w_mis;
        w_new.rd   = in_rd;
        w_new.data = w_data;
    end

    assign in_ready = ~skid_q.v;
    assign w_acc    = in_valid & in_ready & ~flush;
    assign w_pop    = main_q.v & out_ready;

    // Skid is only ever filled while main is held, so main is never empty
    // while skid is valid; this keeps the pop/accept cases disjoint.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d.v = 1'b0;
            skid_d.v = 1'b0;
        end else if (w_pop) begin
            if (skid_q.v) begin
                main_d   = skid_q;
                skid_d.v = 1'b0;
            end else if (w_acc) begin
                main_d = w_new;
            end else begin
                main_d.v = 1'b0;
            end
        end else if (w_acc) begin
            if (!main_q.v) begin
                main_d = w_new;
            end else begin
                skid_d = w_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_valid    = main_q.v;
    assign grf_we       = main_q.v & out_ready & main_q.we & (main_q.rd != '0);
    assign grf_addr     = main_q.rd;
    assign grf_wdata    = main_q.data;
    assign exc_misalign = main_q.v & main_q.mis;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_result_stage
// Brief    : Self-checking bench for wb_result_stage: table of single-entry
//            vectors plus hand-written backpressure/flush/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_sel;
    logic [4:0]  in_rd, grf_addr;
    logic [31:0] in_alu, in_mem, in_pc, in_hi, in_lo, in_cp0, grf_wdata;
    logic [15:0] in_imm;
    logic        grf_we, exc_misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_result_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
        .in_pc(in_pc), .in_imm(in_imm), .in_hi(in_hi), .in_lo(in_lo),
        .in_cp0(in_cp0), .out_valid(out_valid), .out_ready(out_ready),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .exc_misalign(exc_misalign)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        gwe;
        logic [31:0] data;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [15:0] imm);
        in_valid = v;
        in_sel   = sel;
        in_rd    = rd;
        in_alu   = alu;
        in_mem   = mem;
        in_pc    = pc;
        in_imm   = imm;
    endtask

    int          pulses;
    logic [31:0] exp_q [$];

    initial begin
        vec[0]  = '{4'd6,  5'd1,  32'h3,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'hFFFFFF80};
        vec[1]  = '{4'd8,  5'd2,  32'h3,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'h00000080};
        vec[2]  = '{4'd6,  5'd3,  32'h0,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'h00000001};
        vec[3]  = '{4'd6,  5'd4,  32'h1,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'h0000007F};
        vec[4]  = '{4'd8,  5'd5,  32'h2,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'h000000FF};
        vec[5]  = '{4'd7,  5'd6,  32'h2,        32'h80011234, 32'h0,        16'h0,    1'b1, 32'hFFFF8001};
        vec[6]  = '{4'd10, 5'd7,  32'h2,        32'h80011234, 32'h0,        16'h0,    1'b1, 32'h00008001};
        vec[7]  = '{4'd7,  5'd8,  32'h0,        32'h0000F234, 32'h0,        16'h0,    1'b1, 32'hFFFFF234};
        vec[8]  = '{4'd3,  5'd9,  32'h0,        32'h0,        32'h0,        16'h1234, 1'b1, 32'h12340000};
        vec[9]  = '{4'd2,  5'd31, 32'h0,        32'h0,        32'h00003000, 16'h0,    1'b1, 32'h00003008};
        vec[10] = '{4'd0,  5'd10, 32'hDEADBEEF, 32'h0,        32'h0,        16'h0,    1'b1, 32'hDEADBEEF};
        vec[11] = '{4'd1,  5'd11, 32'h0,        32'hCAFEF00D, 32'h0,        16'h0,    1'b1, 32'hCAFEF00D};
        vec[12] = '{4'd4,  5'd12, 32'h0,        32'h0,        32'h0,        16'h0,    1'b1, 32'h11112222};
        vec[13] = '{4'd5,  5'd13, 32'h0,        32'h0,        32'h0,        16'h0,    1'b1, 32'h33334444};
        vec[14] = '{4'd9,  5'd14, 32'h0,        32'h0,        32'h0,        16'h0,    1'b1, 32'h55556666};
        vec[15] = '{4'd11, 5'd15, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,        16'hFFFF, 1'b0, 32'h00000000};
        vec[16] = '{4'd15, 5'd16, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,        16'hFFFF, 1'b0, 32'h00000000};
        vec[17] = '{4'd0,  5'd0,  32'h12345678, 32'h0,        32'h0,        16'h0,    1'b0, 32'h12345678};
        vec[18] = '{4'd6,  5'd17, 32'h2,        32'h80FF7F01, 32'h0,        16'h0,    1'b1, 32'hFFFFFFFF};

        in_hi  = 32'h11112222;
        in_lo  = 32'h33334444;
        in_cp0 = 32'h55556666;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_grf_we",    32'(grf_we),    32'd0);
        chk("rst_grf_addr",  32'(grf_addr),  32'd0);
        chk("rst_grf_wdata", grf_wdata,      32'd0);
        chk("rst_exc",       32'(exc_misalign), 32'd0);

        // Table: one entry in, checked one cycle later, popped the next cycle
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(1'b1, vec[i].sel, vec[i].rd, vec[i].alu, vec[i].mem, vec[i].pc, vec[i].imm);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_grf_we", i),    32'(grf_we),    32'(vec[i].gwe));
            chk($sformatf("v%0d_grf_addr", i),  32'(grf_addr),  32'(vec[i].rd));
            chk($sformatf("v%0d_grf_wdata", i), grf_wdata,      vec[i].data);
            chk($sformatf("v%0d_exc", i),       32'(exc_misalign), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_popped", i),    32'(out_valid), 32'd0);
        end

        // Backpressure: A, B fill the buffer, C must wait
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd1, 32'h0000000A, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 4'd0, 5'd2, 32'h0000000B, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 4'd0, 5'd3, 32'h0000000C, 32'h0, 32'h0, 16'h0);
        #1;
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_grf_we_stall",  32'(grf_we),   32'd0);
        @(negedge clk);
        chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
        chk("bp_main_is_A",     grf_wdata,     32'h0000000A);
        out_ready = 1'b1;
        #1;
        chk("bp_write_A_we",   32'(grf_we), 32'd1);
        chk("bp_write_A_addr", 32'(grf_addr), 32'd1);
        @(negedge clk); #1;
        chk("bp_write_B_we",   32'(grf_we), 32'd1);
        chk("bp_write_B_data", grf_wdata,   32'h0000000B);
        chk("bp_in_ready_B",   32'(in_ready), 32'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        chk("bp_write_C_we",   32'(grf_we), 32'd1);
        chk("bp_write_C_data", grf_wdata,   32'h0000000C);
        @(negedge clk); #1;
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Back-to-back accept and pop for 100 entries
        pulses = 0;
        for (int i = 0; i < 102; i++) begin
            @(negedge clk);
            if (i < 100) begin
                drive(1'b1, 4'd0, 5'((i % 31) + 1), 32'(i * 3 + 7), 32'h0, 32'h0, 16'h0);
                exp_q.push_back(32'(i * 3 + 7));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (grf_we) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("b2b_extra_write", grf_wdata, 32'hFFFFFFFF);
                end else begin
                    chk("b2b_data", grf_wdata, exp_q.pop_front());
                end
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd100);

        // Flush with both entries full; the accept in the flush cycle is dropped
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd4, 32'h44, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 4'd0, 5'd5, 32'h55, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        drive(1'b1, 4'd0, 5'd6, 32'h66, 32'h0, 32'h0, 16'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        #1;
        chk("fl_no_write", 32'(grf_we), 32'd0);
        @(negedge clk);
        chk("fl_still_empty", 32'(out_valid), 32'd0);

        // Pop in the flush cycle still writes
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd7, 32'h77, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flpop_grf_we", 32'(grf_we), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flpop_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while main is valid
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd8, 32'h88, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ar_loaded", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_grf_we",    32'(grf_we),    32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Halfword load with address bit 0 set
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 5'd3, 32'h1, 32'h80011234, 32'h0, 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
`ifdef WB_ALIGN_CHECK_EN
        chk("mis_exc",      32'(exc_misalign), 32'd1);
        @(negedge clk);
        chk("mis_exc_held", 32'(exc_misalign), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("mis_grf_we",   32'(grf_we), 32'd0);
`else
        chk("mis_exc",      32'(exc_misalign), 32'd0);
        chk("mis_data",     grf_wdata, 32'h00001234);
        out_ready = 1'b1;
        #1;
        chk("mis_grf_we",   32'(grf_we), 32'd1);
`endif
        @(negedge clk); #1;
        chk("mis_popped",   32'(out_valid), 32'd0);
        chk("mis_exc_clr",  32'(exc_misalign), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
